pipe_add_acc: RTL



---
 rtl/pipe_add_acc.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_add_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_add_acc
// Description : Pipelined two-operand arithmetic unit with valid/ready
//               handshaking. Per-transaction add, subtract, running
//               accumulate and accumulator clear. Configurable operand
//               width, output width and pipeline depth, full backpressure.
//               Optional macro SATURATE_EN: accumulate clamps at the
//               maximum value and flags out_ovf instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_add_acc #(
    parameter int DATA_W      = 9,
    parameter int ACC_W       = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ovf
);

    localparam logic [1:0] c_MODE_ADD = 2'b00;
    localparam logic [1:0] c_MODE_SUB = 2'b01;
    localparam logic [1:0] c_MODE_ACC = 2'b10;
    localparam logic [1:0] c_MODE_CLR = 2'b11;
    localparam int         c_LAST     = PIPE_STAGES - 1;

    // Pipeline state: one valid/data/ovf slot per stage, last slot drives outputs
    logic [PIPE_STAGES-1:0] r_vld;
    logic [ACC_W-1:0]       r_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] r_ovf;
    logic [ACC_W-1:0]       r_acc;

    logic                   w_stall;
    logic                   w_accept;
    logic [DATA_W:0]        w_sum;
    logic [DATA_W:0]        w_diff;
    logic [ACC_W-1:0]       w_addend;
    logic [ACC_W-1:0]       w_acc_next;
    logic                   w_acc_sat;
    logic [ACC_W-1:0]       w_res;
    logic                   w_res_ovf;

    // The whole pipe freezes only when the consumer refuses a valid result;
    // bubbles are not squeezed out, so a stall is purely an output condition.
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign w_accept  = in_valid & in_ready;

    assign out_valid = r_vld[c_LAST];
    assign data_out  = r_data[c_LAST];
    assign out_ovf   = r_ovf[c_LAST];

    // Operand arithmetic, one bit wider than the operands so nothing is lost
    assign w_sum    = {1'b0, data_in0} + {1'b0, data_in1};
    assign w_diff   = {1'b0, data_in0} - {1'b0, data_in1};
    // A+B always fits in DATA_W+1 bits, so it can be added to acc as one term
    assign w_addend = {{(ACC_W-DATA_W-1){1'b0}}, w_sum};

`ifdef SATURATE_EN
    logic [ACC_W:0] w_acc_wide;

    // Carry out of the accumulator width means the true sum exceeded max
    assign w_acc_wide = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_acc_sat  = w_acc_wide[ACC_W];
    assign w_acc_next = w_acc_sat ? {ACC_W{1'b1}} : w_acc_wide[ACC_W-1:0];
`else
    // Plain modulo-2^ACC_W accumulation
    assign w_acc_next = r_acc + w_addend;
    assign w_acc_sat  = 1'b0;
`endif

    // Result selection for the transaction being accepted this cycle
    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        case (mode)
            c_MODE_ADD: w_res = {{(ACC_W-DATA_W-1){1'b0}}, w_sum};
            c_MODE_SUB: w_res = {{(ACC_W-DATA_W-1){w_diff[DATA_W]}}, w_diff};
            c_MODE_ACC: begin
                w_res     = w_acc_next;
                w_res_ovf = w_acc_sat;
            end
            c_MODE_CLR: w_res = '0;
            default:    w_res = '0;
        endcase
    end

    // Accumulator updates at the acceptance edge so back-to-back accumulates chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            if (mode == c_MODE_ACC) begin
                r_acc <= w_acc_next;
            end else if (mode == c_MODE_CLR) begin
                r_acc <= '0;
            end
        end
    end

    // Stage 1 captures the result; later stages only delay it, all hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_ovf <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else if (!w_stall) begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_data[0] <= w_res;
                r_ovf[0]  <= w_res_ovf;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
                r_ovf[i]  <= r_ovf[i-1];
            end
        end
    end

endmodule
`default_nettype wire
